dfi_rddata_capture: RTL and testbench

// - Read-return stage on the controller side of the DFI master port.
// - Consumes dfi_rddata/dfi_rddata_valid from the PHY and packs phase beats

---
 rtl/dfi_rddata_capture.sv | 216 +++++++++++++++++++++
 tb/tb_dfi_rddata_capture.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfi_rddata_capture.sv
// DFI read-return capture: packs phase beats into words, tags each word with its command ID
// and streams words out of a first-word fall-through FIFO. Optional watchdog: DFI_RDCAP_TIMEOUT_EN.
module dfi_rddata_capture #(
    parameter int unsigned C_DFI_FREQ_RATIO  = 4,
    parameter int unsigned C_DFI_DATA_WIDTH  = 32,
    parameter int unsigned C_BURST_BEATS     = 8,
    parameter int unsigned C_ID_WIDTH        = 4,
    parameter int unsigned C_FIFO_DEPTH      = 8,
    parameter int unsigned C_MAX_OUTSTANDING = 4,
    parameter int unsigned C_TIMEOUT         = 255
) (
    input  logic                                               aclk,
    input  logic                                               aresetn,
    input  logic                                               rd_cmd_valid,
    output logic                                               rd_cmd_ready,
    input  logic [C_ID_WIDTH-1:0]                              rd_cmd_id,
    input  logic [C_DFI_DATA_WIDTH-1:0][C_DFI_FREQ_RATIO-1:0]  dfi_rddata,
    input  logic [C_DFI_FREQ_RATIO-1:0]                        dfi_rddata_valid,
    output logic                                               rd_data_valid,
    input  logic                                               rd_data_ready,
    output logic [C_DFI_DATA_WIDTH*C_DFI_FREQ_RATIO-1:0]       rd_data,
    output logic [C_ID_WIDTH-1:0]                              rd_data_id,
    output logic                                               rd_data_last,
    output logic                                               err_overflow,
    output logic                                               err_unexpected,
    output logic                                               err_timeout
);
    localparam int unsigned R   = C_DFI_FREQ_RATIO;
    localparam int unsigned DW  = C_DFI_DATA_WIDTH;
    localparam int unsigned WPB = C_BURST_BEATS / R;
    localparam int unsigned HW  = $clog2(2 * R);
    localparam int unsigned FAW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int unsigned FCW = $clog2(C_FIFO_DEPTH + 1);
    localparam int unsigned TAW = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
    localparam int unsigned TCW = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int unsigned OWW = $clog2(C_MAX_OUTSTANDING * WPB + 1);
    localparam int unsigned WCW = (WPB > 1) ? $clog2(WPB) : 1;

    typedef logic [DW-1:0] beat_t;
    typedef struct packed {
        logic [DW*R-1:0]       data;
        logic [C_ID_WIDTH-1:0] id;
        logic                  last;
    } entry_t;

    logic [C_ID_WIDTH-1:0] tag_mem_q [C_MAX_OUTSTANDING];
    logic [TAW-1:0]        tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [TCW-1:0]        tag_cnt_q, tag_cnt_d;
    entry_t                fifo_mem_q [C_FIFO_DEPTH];
    logic [FAW-1:0]        fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [FCW-1:0]        fifo_cnt_q, fifo_cnt_d;
    beat_t                 hold_q [R-1];
    beat_t                 hold_d [R-1];
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic [OWW-1:0]        owed_q, owed_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  err_ovf_q, err_ovf_d, err_unexp_q, err_unexp_d;

    beat_t           in_beat [R];
    beat_t           comb [2*R-1];
    logic [DW*R-1:0] word;
    logic            word_wr, word_last, unexpected;
    logic            cmd_fire, tag_pop, fifo_push, fifo_pop, fifo_full;
    entry_t          fifo_wdata;

    // Beat p lives in bit-column p of dfi_rddata.
    always_comb begin
        for (int p = 0; p < R; p++) begin
            for (int b = 0; b < DW; b++) begin
                in_beat[p][b] = dfi_rddata[b][p];
            end
        end
    end

    // Beats are only accepted while outstanding bursts still owe beats; the rest are unexpected.
    always_comb begin
        int n;
        int room;
        comb = '{default: '0};
        for (int j = 0; j < R - 1; j++) comb[j] = hold_q[j];
        n    = int'(hold_cnt_q);
        room = int'(owed_q) * int'(R) - int'(hold_cnt_q);
        unexpected = 1'b0;
        for (int p = 0; p < R; p++) begin
            if (dfi_rddata_valid[p]) begin
                if (n - int'(hold_cnt_q) < room) begin
                    for (int j = 0; j < 2 * R - 1; j++) begin
                        if (j == n) comb[j] = in_beat[p];
                    end
                    n = n + 1;
                end else begin
                    unexpected = 1'b1;
                end
            end
        end
        word_wr = (n >= int'(R));
        word    = '0;
        for (int k = 0; k < R; k++) word[k*DW +: DW] = comb[k];
        for (int j = 0; j < R - 1; j++) hold_d[j] = word_wr ? comb[j+R] : comb[j];
        hold_cnt_d = word_wr ? HW'(n - int'(R)) : HW'(n);
    end

    always_comb begin
        cmd_fire  = rd_cmd_valid & cmd_ready_q;
        word_last = (wcnt_q == WCW'(WPB - 1));
        tag_pop   = word_wr & word_last;
        fifo_pop  = (fifo_cnt_q != '0) & rd_data_ready;
        fifo_full = (fifo_cnt_q == FCW'(C_FIFO_DEPTH));
        fifo_push = word_wr & (~fifo_full | fifo_pop);

        fifo_wdata.data = word;
        fifo_wdata.id   = tag_mem_q[tag_rp_q];
        fifo_wdata.last = word_last;

        tag_wp_d = tag_wp_q;
        tag_rp_d = tag_rp_q;
        if (cmd_fire) tag_wp_d = (tag_wp_q == TAW'(C_MAX_OUTSTANDING - 1)) ? '0 : tag_wp_q + TAW'(1);
        if (tag_pop)  tag_rp_d = (tag_rp_q == TAW'(C_MAX_OUTSTANDING - 1)) ? '0 : tag_rp_q + TAW'(1);
        tag_cnt_d = tag_cnt_q + (cmd_fire ? TCW'(1) : '0) - (tag_pop ? TCW'(1) : '0);

        fifo_wp_d = fifo_wp_q;
        fifo_rp_d = fifo_rp_q;
        if (fifo_push) fifo_wp_d = (fifo_wp_q == FAW'(C_FIFO_DEPTH - 1)) ? '0 : fifo_wp_q + FAW'(1);
        if (fifo_pop)  fifo_rp_d = (fifo_rp_q == FAW'(C_FIFO_DEPTH - 1)) ? '0 : fifo_rp_q + FAW'(1);
        fifo_cnt_d = fifo_cnt_q + (fifo_push ? FCW'(1) : '0) - (fifo_pop ? FCW'(1) : '0);

        wcnt_d = word_wr ? (word_last ? '0 : wcnt_q + WCW'(1)) : wcnt_q;
        owed_d = owed_q + (cmd_fire ? OWW'(WPB) : '0) - (word_wr ? OWW'(1) : '0);

        // Registered so the credit never depends combinationally on rd_cmd_valid.
        cmd_ready_d = (int'(tag_cnt_d) < int'(C_MAX_OUTSTANDING)) &&
                      (int'(fifo_cnt_d) + int'(owed_d) + int'(WPB) <= int'(C_FIFO_DEPTH));

        err_ovf_d   = err_ovf_q | (word_wr & fifo_full & ~fifo_pop);
        err_unexp_d = err_unexp_q | unexpected;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tag_wp_q    <= '0;
            tag_rp_q    <= '0;
            tag_cnt_q   <= '0;
            fifo_wp_q   <= '0;
            fifo_rp_q   <= '0;
            fifo_cnt_q  <= '0;
            hold_q      <= '{default: '0};
            hold_cnt_q  <= '0;
            wcnt_q      <= '0;
            owed_q      <= '0;
            cmd_ready_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            tag_wp_q    <= tag_wp_d;
            tag_rp_q    <= tag_rp_d;
            tag_cnt_q   <= tag_cnt_d;
            fifo_wp_q   <= fifo_wp_d;
            fifo_rp_q   <= fifo_rp_d;
            fifo_cnt_q  <= fifo_cnt_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            wcnt_q      <= wcnt_d;
            owed_q      <= owed_d;
            cmd_ready_q <= cmd_ready_d;
            err_ovf_q   <= err_ovf_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (cmd_fire)  tag_mem_q[tag_wp_q]   <= rd_cmd_id;
        if (fifo_push) fifo_mem_q[fifo_wp_q] <= fifo_wdata;
    end

    assign rd_cmd_ready   = cmd_ready_q;
    assign rd_data_valid  = (fifo_cnt_q != '0);
    assign rd_data        = rd_data_valid ? fifo_mem_q[fifo_rp_q].data : '0;
    assign rd_data_id     = rd_data_valid ? fifo_mem_q[fifo_rp_q].id : '0;
    assign rd_data_last   = rd_data_valid & fifo_mem_q[fifo_rp_q].last;
    assign err_overflow   = err_ovf_q;
    assign err_unexpected = err_unexp_q;

`ifdef DFI_RDCAP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(C_TIMEOUT + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          err_to_q, err_to_d;

    // Counts idle cycles while bursts are outstanding; saturates at the limit.
    always_comb begin
        wd_d     = wd_q;
        err_to_d = err_to_q;
        if (tag_cnt_q == '0 || dfi_rddata_valid != '0) begin
            wd_d = '0;
        end else if (wd_q != TW'(C_TIMEOUT)) begin
            wd_d = wd_q + TW'(1);
        end
        if (wd_d == TW'(C_TIMEOUT)) err_to_d = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dfi_rddata_capture.sv
// Bench for dfi_rddata_capture: a queue-based model checked every cycle, plus directed
// scenarios with literal expected words.
module tb_dfi_rddata_capture;
    localparam int unsigned R     = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned IDW   = 4;
    localparam int unsigned BURST = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 4;
    localparam int unsigned WPB   = BURST / R;

`ifdef DFI_RDCAP_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [DW*R-1:0] data;
        logic [IDW-1:0]  id;
        logic            last;
    } word_s;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic                     rd_cmd_valid = 1'b0;
    logic                     rd_cmd_ready;
    logic [IDW-1:0]           rd_cmd_id = '0;
    logic [DW-1:0][R-1:0]     dfi_rddata = '0;
    logic [R-1:0]             dfi_rddata_valid = '0;
    logic                     rd_data_valid;
    logic                     rd_data_ready = 1'b0;
    logic [DW*R-1:0]          rd_data;
    logic [IDW-1:0]           rd_data_id;
    logic                     rd_data_last;
    logic                     err_overflow, err_unexpected, err_timeout;

    int n_vec  = 0;
    int n_miss = 0;
    int bv     = 0;

    dfi_rddata_capture #(
        .C_DFI_FREQ_RATIO (R),
        .C_DFI_DATA_WIDTH (DW),
        .C_BURST_BEATS    (BURST),
        .C_ID_WIDTH       (IDW),
        .C_FIFO_DEPTH     (DEPTH),
        .C_MAX_OUTSTANDING(MAXO),
        .C_TIMEOUT        (16)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .rd_cmd_valid    (rd_cmd_valid),
        .rd_cmd_ready    (rd_cmd_ready),
        .rd_cmd_id       (rd_cmd_id),
        .dfi_rddata      (dfi_rddata),
        .dfi_rddata_valid(dfi_rddata_valid),
        .rd_data_valid   (rd_data_valid),
        .rd_data_ready   (rd_data_ready),
        .rd_data         (rd_data),
        .rd_data_id      (rd_data_id),
        .rd_data_last    (rd_data_last),
        .err_overflow    (err_overflow),
        .err_unexpected  (err_unexpected),
        .err_timeout     (err_timeout)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: beats, tags and words as plain queues.
    logic [IDW-1:0] tagq[$];
    logic [DW-1:0]  bq[$];
    word_s          outq[$];
    int             widx = 0;
    int             budget = 0;
    logic           m_ready = 1'b0;
    logic           m_ovf = 1'b0;
    logic           m_unexp = 1'b0;
    bit             started = 1'b0;

    always @(posedge aclk) begin : model
        logic            pop, fire;
        logic [DW-1:0]   bt;
        logic [DW*R-1:0] w;
        word_s           e;
        if (!aresetn) begin
            tagq.delete();
            bq.delete();
            outq.delete();
            widx = 0;
            budget = 0;
            m_ready = 1'b0;
            m_ovf = 1'b0;
            m_unexp = 1'b0;
        end else begin
            pop  = (outq.size() > 0) && rd_data_ready;
            fire = m_ready && rd_cmd_valid;
            for (int p = 0; p < R; p++) begin
                if (dfi_rddata_valid[p]) begin
                    for (int b = 0; b < DW; b++) bt[b] = dfi_rddata[b][p];
                    if (budget > 0) begin
                        bq.push_back(bt);
                        budget--;
                    end else begin
                        m_unexp = 1'b1;
                    end
                end
            end
            if (pop) void'(outq.pop_front());
            if (bq.size() >= R) begin
                for (int k = 0; k < R; k++) w[k*DW +: DW] = bq.pop_front();
                e.data = w;
                e.id   = tagq[0];
                e.last = (widx == WPB - 1);
                if (e.last) begin
                    void'(tagq.pop_front());
                    widx = 0;
                end else begin
                    widx++;
                end
                if (outq.size() == DEPTH) m_ovf = 1'b1;
                else outq.push_back(e);
            end
            if (fire) begin
                tagq.push_back(rd_cmd_id);
                budget += BURST;
            end
            m_ready = (tagq.size() < MAXO) &&
                      (outq.size() + tagq.size() * WPB - widx + WPB <= DEPTH);
        end
        started = 1'b1;
    end

    always @(negedge aclk) begin
        if (started) begin
            chk("cmd_ready", 128'(rd_cmd_ready), 128'(m_ready));
            chk("data_valid", 128'(rd_data_valid), 128'(outq.size() > 0));
            if (outq.size() > 0) begin
                chk("data", 128'(rd_data), 128'(outq[0].data));
                chk("data_id", 128'(rd_data_id), 128'(outq[0].id));
                chk("data_last", 128'(rd_data_last), 128'(outq[0].last));
            end
            chk("err_overflow", 128'(err_overflow), 128'(m_ovf));
            chk("err_unexpected", 128'(err_unexpected), 128'(m_unexp));
        end
    end

    task automatic step();
        @(negedge aclk);
    endtask

    task automatic issue(input logic [IDW-1:0] id);
        rd_cmd_valid = 1'b1;
        rd_cmd_id    = id;
        step();
        rd_cmd_valid = 1'b0;
    endtask

    // Valid phases get ascending beat values; invalid phases carry junk that must be skipped.
    task automatic drive(input logic [R-1:0] v);
        logic [DW-1:0] beat;
        for (int p = 0; p < R; p++) begin
            beat = v[p] ? DW'(bv) : (32'hDEAD_0000 + DW'(p));
            if (v[p]) bv++;
            for (int b = 0; b < DW; b++) dfi_rddata[b][p] = beat[b];
        end
        dfi_rddata_valid = v;
        step();
        dfi_rddata_valid = '0;
    endtask

    task automatic expect_word(input string nm, input logic [127:0] d,
                               input logic [IDW-1:0] id, input logic last);
        int n = 0;
        while (!rd_data_valid && n < 20) begin
            step();
            n++;
        end
        chk({nm, " valid"}, 128'(rd_data_valid), 128'(1));
        chk({nm, " data"}, 128'(rd_data), d);
        chk({nm, " id"}, 128'(rd_data_id), 128'(id));
        chk({nm, " last"}, 128'(rd_data_last), 128'(last));
        rd_data_ready = 1'b1;
        step();
        rd_data_ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("reset cmd_ready", 128'(rd_cmd_ready), 128'(0));
        chk("reset data_valid", 128'(rd_data_valid), 128'(0));
        aresetn = 1'b1;
        step();
        chk("post-reset cmd_ready", 128'(rd_cmd_ready), 128'(1));

        // Single burst at half rate.
        bv = 0;
        issue(4'd3);
        repeat (4) drive(4'b0011);
        expect_word("t1 w0", {32'd3, 32'd2, 32'd1, 32'd0}, 4'd3, 1'b0);
        expect_word("t1 w1", {32'd7, 32'd6, 32'd5, 32'd4}, 4'd3, 1'b1);
        chk("t1 cmd_ready", 128'(rd_cmd_ready), 128'(1));

        // Sparse valids with a carried remainder.
        bv = 0;
        issue(4'd7);
        drive(4'b1010);
        drive(4'b1101);
        drive(4'b0111);
        expect_word("t2 w0", {32'd3, 32'd2, 32'd1, 32'd0}, 4'd7, 1'b0);
        expect_word("t2 w1", {32'd7, 32'd6, 32'd5, 32'd4}, 4'd7, 1'b1);

        // Back-to-back bursts at full rate.
        bv = 0;
        issue(4'd1);
        issue(4'd2);
        repeat (4) drive(4'hF);
        expect_word("t5 w0", {32'd3, 32'd2, 32'd1, 32'd0}, 4'd1, 1'b0);
        expect_word("t5 w1", {32'd7, 32'd6, 32'd5, 32'd4}, 4'd1, 1'b1);
        expect_word("t5 w2", {32'd11, 32'd10, 32'd9, 32'd8}, 4'd2, 1'b0);
        expect_word("t5 w3", {32'd15, 32'd14, 32'd13, 32'd12}, 4'd2, 1'b1);

        // Credit exhaustion with the consumer stalled.
        bv = 0;
        issue(4'd5);
        issue(4'd6);
        chk("t3 cmd_ready after two", 128'(rd_cmd_ready), 128'(0));
        issue(4'd8);
        repeat (4) drive(4'hF);
        chk("t3 cmd_ready fifo full", 128'(rd_cmd_ready), 128'(0));
        expect_word("t3 w0", {32'd3, 32'd2, 32'd1, 32'd0}, 4'd5, 1'b0);
        expect_word("t3 w1", {32'd7, 32'd6, 32'd5, 32'd4}, 4'd5, 1'b1);
        chk("t3 cmd_ready drained", 128'(rd_cmd_ready), 128'(1));
        expect_word("t3 w2", {32'd11, 32'd10, 32'd9, 32'd8}, 4'd6, 1'b0);
        expect_word("t3 w3", {32'd15, 32'd14, 32'd13, 32'd12}, 4'd6, 1'b1);

        // Beats with nothing outstanding.
        drive(4'hF);
        chk("t4 err_unexpected", 128'(err_unexpected), 128'(1));
        chk("t4 data_valid", 128'(rd_data_valid), 128'(0));

        // Reset in the middle of a burst.
        bv = 0;
        issue(4'd9);
        drive(4'b0011);
        aresetn = 1'b0;
        step();
        chk("t6 cmd_ready", 128'(rd_cmd_ready), 128'(0));
        chk("t6 data_valid", 128'(rd_data_valid), 128'(0));
        chk("t6 data", 128'(rd_data), 128'(0));
        chk("t6 id", 128'(rd_data_id), 128'(0));
        chk("t6 last", 128'(rd_data_last), 128'(0));
        chk("t6 err_overflow", 128'(err_overflow), 128'(0));
        chk("t6 err_unexpected", 128'(err_unexpected), 128'(0));
        chk("t6 err_timeout", 128'(err_timeout), 128'(0));
        step();
        aresetn = 1'b1;
        step();
        bv = 0;
        issue(4'd10);
        repeat (2) drive(4'hF);
        expect_word("t6 w0", {32'd3, 32'd2, 32'd1, 32'd0}, 4'd10, 1'b0);
        expect_word("t6 w1", {32'd7, 32'd6, 32'd5, 32'd4}, 4'd10, 1'b1);
        chk("t6 err_unexpected clean", 128'(err_unexpected), 128'(0));

        // Watchdog: one command, no beats.
        issue(4'd1);
        repeat (8) step();
        chk("t7 err_timeout early", 128'(err_timeout), 128'(0));
        repeat (12) step();
        chk("t7 err_timeout late", 128'(err_timeout), 128'(TO_EXP));
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
